bcd_to_bin_controller: RTL and testbench
========================================

# bcd_to_bin_controller

Sequential decimal-to-binary converter: the inverse of the display-side binary-to-BCD path. It accepts four BCD digits (D1 most significant) from keypad/switch entry logic and produces a 16-bit unsigned binary value for the angle/threshold registers feeding the cube renderer. Conversion is an iterative multiply-by-ten accumulate, one digit per clock, with a start/busy/done handshake and an invalid-digit error flag.

## Interface
- CHECK_DIGITS, default 1: 1 = digits > 9 flagged as error; 0 = no check, raw nibble values accumulated.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request conversion; sampled only in IDLE.
- D1  in  4  thousands digit (BCD).
- D2  in  4  hundreds digit.
- D3  in  4  tens digit.
- D4  in  4  units digit.
- data  out  16  converted binary value, zero-extended (max 9999 = 16'h270F).
- busy  out  1  high from the edge after start is accepted until done deasserts.
- done  out  1  one-cycle pulse; data/err valid from this cycle.
- err  out  1  high with done when any latched digit > 9 (CHECK_DIGITS=1); held until next done.

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE: busy=0. On edge with start=1: latch D1..D4 into digit register, acc<=0, cnt<=0, state->ACCUM.
- ACCUM: each edge acc <= acc*10 + digit[cnt] (D1 first), cnt++. acc*10 computed as (acc<<3)+(acc<<1), 16-bit; no overflow possible with valid digits.
- On the 4th ACCUM edge (cnt=3): data <= acc*10 + D4_latched, err <= invalid flag, done <= 1, state->DONE.
- Invalid flag: OR of (digit > 9) over all four latched digits, computed at latch time. If set, data <= 0 instead of the sum.
- DONE: done=1 for this cycle only; next edge state->IDLE, done<=0.
- D1..D4 changes after the start edge have no effect (latched copy used).
- start while busy or in DONE: ignored, not queued.
- data and err hold their value between conversions.
- CHECK_DIGITS=0: err stays 0; nibble arithmetic wraps modulo 2^16 (max 15*1111+... fits, no wrap in practice).

## Timing
- Reset values: data=16'h0000, done=0, busy=0, err=0, state=IDLE, acc=0, cnt=0.
- start sampled at edge E -> busy high after E through E+4; data/done/err updated at edge E+4; done low again after E+5; busy low after E+4... specifically busy deasserts together with done (after E+5).
- Earliest next accepted start: edge E+6 (first IDLE edge) — throughput one conversion per 6 cycles.
- rst asserted mid-conversion: immediate return to reset values; no done pulse; partial result discarded.
- rst released with start high: start acted on at first rising edge where rst is low.

## Structure
- Shared package (cube_demo_pkg): state encoding constants (IDLE/ACCUM/DONE), NUM_DIGITS=4, BCD_MAX=9, BIN_WIDTH=16.
- Single module; the multiply-by-ten accumulate is a one-line expression, no sub-module. Optional helper function bcd_valid(nibble) lives in the package.

## Test plan
- Digits 0,0,0,0 + start -> after 4 edges done=1, data=16'h0000, err=0; busy high 5 cycles.
- Digits 0,3,6,0 -> data=16'h0168 (360), err=0; change D1..D4 to 9,9,9,9 during ACCUM -> result still 360.
- Digits 9,9,9,9 -> data=16'h270F, err=0; then 1,2,3,4 back-to-back at earliest IDLE edge -> data=16'h04D2.
- Digits 0,A,0,1 (CHECK_DIGITS=1) -> done=1, err=1, data=0; next valid conversion clears err.
- start held high continuously -> conversions accepted only at IDLE edges, one done pulse per 6 cycles; extra start pulses during busy produce no extra done.
- rst pulsed at 2nd ACCUM cycle -> all outputs 0 asynchronously, no done; subsequent 0,0,4,2 conversion yields data=16'h002A.

Source files
------------

// File: rtl/cube_demo_pkg.sv
// Shared definitions for the cube demo datapath: FSM states, BCD limits and
// the binary result width used by the decimal-to-binary converter.
package cube_demo_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_DONE
   } state_t;

   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned BCD_MAX    = 9;
   localparam int unsigned BIN_WIDTH  = 16;

   function automatic logic bcd_valid(input logic [3:0] nibble);
      return nibble <= 4'(BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_to_bin_controller.sv
// Four-digit BCD to 16-bit binary converter: one multiply-by-ten accumulate
// per clock, start/busy/done handshake and invalid-digit error flag.
module bcd_to_bin_controller
   import cube_demo_pkg::*;
#(
   parameter bit CHECK_DIGITS = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [3:0]           D1,
   input  logic [3:0]           D2,
   input  logic [3:0]           D3,
   input  logic [3:0]           D4,
   output logic [BIN_WIDTH-1:0] data,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   state_t                 r_state;
   state_t                 w_next;
   logic                   w_accept;
   logic                   w_last;
   logic [BIN_WIDTH-1:0]   r_acc;
   logic [1:0]             r_cnt;
   logic [3:0]             r_digit [NUM_DIGITS];
   logic                   r_inv;
   logic                   w_inv;
   logic [3:0]             w_digit;
   logic [BIN_WIDTH-1:0]   w_acc_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      busy     = 1'b0;
      done     = 1'b0;
      w_accept = 1'b0;
      w_last   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_accept = 1'b1;
               w_next   = ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            busy = 1'b1;
            if (r_cnt == 2'(NUM_DIGITS - 1)) begin
               w_last = 1'b1;
               w_next = ST_DONE;
            end
         end
         ST_DONE: begin
            busy   = 1'b1;
            done   = 1'b1;
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   assign w_inv = CHECK_DIGITS &&
                  (!bcd_valid(D1) || !bcd_valid(D2) || !bcd_valid(D3) || !bcd_valid(D4));

   // r_digit[0] holds D1, so the count walks the digits most significant first
   assign w_digit    = r_digit[r_cnt];
   assign w_acc_next = (r_acc << 3) + (r_acc << 1) + {{(BIN_WIDTH-4){1'b0}}, w_digit};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_inv <= 1'b0;
         data  <= '0;
         err   <= 1'b0;
         for (int unsigned i = 0; i < NUM_DIGITS; i++) r_digit[i] <= '0;
      end else if (w_accept) begin
         r_digit[0] <= D1;
         r_digit[1] <= D2;
         r_digit[2] <= D3;
         r_digit[3] <= D4;
         r_inv      <= w_inv;
         r_acc      <= '0;
         r_cnt      <= '0;
      end else if (r_state == ST_ACCUM) begin
         r_acc <= w_acc_next;
         r_cnt <= r_cnt + 2'd1;
         if (w_last) begin
            data <= r_inv ? '0 : w_acc_next;
            err  <= r_inv;
         end
      end
   end

endmodule

// File: tb/tb_bcd_to_bin_controller.sv
// Self-checking bench for bcd_to_bin_controller: directed scenarios plus
// randomized conversions checked against a decimal arithmetic reference.
module tb_bcd_to_bin_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  D1, D2, D3, D4;
   logic [15:0] data;
   logic        busy, done, err;

   int n_cmp = 0;
   int n_bad = 0;

   bcd_to_bin_controller #(.CHECK_DIGITS(1'b1)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .D1    (D1),
      .D2    (D2),
      .D3    (D3),
      .D4    (D4),
      .data  (data),
      .busy  (busy),
      .done  (done),
      .err   (err)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: decimal place value; any digit above nine forces error and zero data
   function automatic logic [16:0] ref_conv(input int a, input int b, input int c, input int d);
      int  v;
      logic e;
      e = (a > 9) || (b > 9) || (c > 9) || (d > 9);
      v = a * 1000 + b * 100 + c * 10 + d;
      if (e) return {1'b1, 16'h0000};
      return {1'b0, 16'(v)};
   endfunction

   // Assumes start was raised at the preceding negedge; samples six negedges after acceptance
   task automatic observe(input logic [15:0] ed, input logic ee, input bit noise, input string tag);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         n_cmp++;
         if (done !== (k == 5)) begin
            n_bad++;
            $display("FAIL %s done@%0d: got %b want %b", tag, k, done, (k == 5));
         end
         n_cmp++;
         if (busy !== (k <= 5)) begin
            n_bad++;
            $display("FAIL %s busy@%0d: got %b want %b", tag, k, busy, (k <= 5));
         end
         if (k >= 5) begin
            n_cmp++;
            if (data !== ed || err !== ee) begin
               n_bad++;
               $display("FAIL %s result@%0d: got data=%h err=%b want data=%h err=%b",
                        tag, k, data, err, ed, ee);
            end
         end
         if (noise && k <= 5) begin
            D1 = 4'($urandom); D2 = 4'($urandom); D3 = 4'($urandom); D4 = 4'($urandom);
            start = 1'($urandom);
         end else begin
            start = 1'b0;
         end
      end
   endtask

   task automatic run_conv(input int a, input int b, input int c, input int d,
                           input bit noise, input string tag);
      logic [16:0] r;
      r = ref_conv(a, b, c, d);
      D1 = 4'(a); D2 = 4'(b); D3 = 4'(c); D4 = 4'(d);
      start = 1'b1;
      observe(r[15:0], r[16], noise, tag);
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1;
      D1 = 4'd1; D2 = 4'd2; D3 = 4'd3; D4 = 4'd4;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (data !== 16'h0000 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_vals: got data=%h busy=%b done=%b err=%b want all zero",
                  data, busy, done, err);
      end
      rst = 1'b0;
      observe(16'h04D2, 1'b0, 1'b0, "reset_release_start_high");
   endtask

   task automatic test_basic();
      run_conv(0, 0, 0, 0, 1'b0, "zeros");
      run_conv(0, 3, 6, 0, 1'b1, "latch_360");
      run_conv(9, 9, 9, 9, 1'b0, "max_9999");
   endtask

   task automatic test_back_to_back();
      run_conv(1, 2, 3, 4, 1'b0, "b2b_1234");
      run_conv(5, 0, 0, 8, 1'b0, "b2b_5008");
   endtask

   task automatic test_invalid();
      run_conv(0, 10, 0, 1, 1'b0, "invalid_0A01");
      run_conv(0, 0, 1, 5, 1'b0, "valid_clears_err");
      run_conv(15, 0, 0, 0, 1'b0, "invalid_F000");
      run_conv(0, 0, 0, 9, 1'b0, "valid_after_F");
   endtask

   task automatic test_start_held();
      D1 = 4'd0; D2 = 4'd0; D3 = 4'd0; D4 = 4'd7;
      start = 1'b1;
      for (int s = 1; s <= 24; s++) begin
         @(negedge clk);
         n_cmp++;
         if (done !== (s % 6 == 5) || busy !== (s % 6 != 0)) begin
            n_bad++;
            $display("FAIL start_held@%0d: got done=%b busy=%b want done=%b busy=%b",
                     s, done, busy, (s % 6 == 5), (s % 6 != 0));
         end
         if (s % 6 == 5) begin
            n_cmp++;
            if (data !== 16'd7) begin
               n_bad++;
               $display("FAIL start_held_data@%0d: got %h want %h", s, data, 16'd7);
            end
         end
      end
      start = 1'b0;
   endtask

   task automatic test_mid_reset();
      bit saw_done;
      run_conv(9, 9, 9, 9, 1'b0, "pre_reset_9999");
      D1 = 4'd5; D2 = 4'd5; D3 = 4'd5; D4 = 4'd5;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp++;
      if (data !== 16'h0000 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_reset_async: got data=%h busy=%b done=%b err=%b want all zero",
                  data, busy, done, err);
      end
      @(negedge clk);
      rst = 1'b0;
      saw_done = 1'b0;
      for (int s = 0; s < 8; s++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
      end
      n_cmp++;
      if (saw_done) begin
         n_bad++;
         $display("FAIL mid_reset_no_done: got activity=1 want 0");
      end
      run_conv(0, 0, 4, 2, 1'b0, "post_reset_42");
   endtask

   task automatic test_random();
      int a, b, c, d;
      for (int i = 0; i < 20; i++) begin
         a = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
         b = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
         c = $urandom_range(0, 9);
         d = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
         run_conv(a, b, c, d, 1'($urandom), $sformatf("rand%0d_%0d%0d%0d%0d", i, a, b, c, d));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_invalid();
      test_start_held();
      test_mid_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
